// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Moore FSM control unit for the 16-bit multicycle datapath. It sequences
// fetch, decode, execute, memory and writeback. It drives every datapath
// enable and mux select, including the ALU operation and operand selects.
// It stalls on memory accesses until mem_ready is seen.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   opcode     IR[15:12], valid from ID onward
//   func       IR[2:0], R-type ALU function
//   zero       ALU zero flag, valid in the same cycle as alu_op
//   mem_ready  memory has completed the access this cycle
//   pc_write   PC load enable (includes the BRZ conditional term)
//   ir_write   IR load enable
//   i_or_d     memory address select: 0 = PC, 1 = IR[11:0]
//   mem_read   memory read strobe
//   mem_write  memory write strobe
//   reg_dst    write register select: 1 = rd, 0 = rt
//   mem_to_reg register write data select: 1 = MDR, 0 = ALUOut
//   reg_write  register file write enable
//   alu_src_a  ALU A select: 0 = PC, 1 = register A
//   alu_src_b  ALU B select: 00 = B, 01 = const 1, 10 = sext IR[8:0]
//   alu_op     000 zero, 001 add, 010 sub, 011 and, 100 or, 101 not B
//   pc_src     00 = ALU result, 01 = ALUOut, 10 = jump target
//   state      current state (debug)
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         opcode,
    input  logic [2:0]         func,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ir_write,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_op,
    output logic [1:0]         pc_src,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        ST_IF     = STATE_W'(0),
        ST_ID     = STATE_W'(1),
        ST_MEM_RD = STATE_W'(2),
        ST_LD_WB  = STATE_W'(3),
        ST_MEM_WR = STATE_W'(4),
        ST_JMP    = STATE_W'(5),
        ST_BRZ    = STATE_W'(6),
        ST_EX_R   = STATE_W'(7),
        ST_WB_R   = STATE_W'(8),
        ST_EX_I   = STATE_W'(9),
        ST_WB_I   = STATE_W'(10)
    } state_t;

    // ALU operation encodings
    localparam logic [2:0] ALU_ZERO = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    // ALU operand B selects
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // PC source selects
    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;

    state_t state_q;
    state_t state_d;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IF;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ZERO;
        pc_src     = PCSRC_ALU;

        case (state_q)
            ST_IF: begin
                // PC + 1 is computed every fetch cycle; it and the IR are only
                // captured once memory delivers the instruction.
                mem_read  = 1'b1;
                i_or_d    = 1'b0;
                alu_src_a = 1'b0;
                alu_src_b = SRCB_ONE;
                alu_op    = ALU_ADD;
                pc_src    = PCSRC_ALU;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_d = ST_ID;
                end
            end

            ST_ID: begin
                // Branch target PC + sext(IR[8:0]) lands in ALUOut for BRZ.
                alu_src_a = 1'b0;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
                casez (opcode)
                    4'b0000: state_d = ST_MEM_RD;
                    4'b0001: state_d = ST_MEM_WR;
                    4'b0010: state_d = ST_JMP;
                    4'b0100: state_d = ST_BRZ;
                    4'b1000: state_d = ST_EX_R;
                    4'b11??: state_d = ST_EX_I;
                    default: state_d = ST_IF;
                endcase
            end

            ST_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = ST_LD_WB;
                end
            end

            ST_LD_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                reg_dst    = 1'b0;
                state_d    = ST_IF;
            end

            ST_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    state_d = ST_IF;
                end
            end

            ST_JMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
                state_d  = ST_IF;
            end

            ST_BRZ: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_op    = ALU_SUB;
                pc_src    = PCSRC_OUT;
                pc_write  = zero;
                state_d   = ST_IF;
            end

            ST_EX_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                // Undefined functions fall back to the zero op; the writeback
                // still happens and stores 0.
                if ((func >= 3'd1) && (func <= 3'd5)) begin
                    alu_op = func;
                end else begin
                    alu_op = ALU_ZERO;
                end
                state_d = ST_WB_R;
            end

            ST_WB_R: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                mem_to_reg = 1'b0;
                state_d    = ST_IF;
            end

            ST_EX_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                // ADDI/SUBI/ANDI/ORI map onto add/sub/and/or in order.
                alu_op    = {1'b0, opcode[1:0]} + 3'd1;
                state_d   = ST_WB_I;
            end

            ST_WB_I: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b0;
                mem_to_reg = 1'b0;
                state_d    = ST_IF;
            end

            default: begin
                state_d = ST_IF;
            end
        endcase

        // Reset silences every strobe in the same cycle, so a write in
        // progress is dropped before the state register returns to IF.
        if (rst) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            i_or_d     = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = SRCB_REG;
            alu_op     = ALU_ZERO;
            pc_src     = PCSRC_ALU;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed bench for multicycle_controller. Each step sets inputs shortly after
// a rising edge and then checks the state and the packed control outputs
// against hand-written expected values. After that it advances one clock.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic [2:0] func;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic [3:0] state;

    int unsigned errors = 0;
    int unsigned checks = 0;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .func       (func),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed control word, MSB first:
    // pc_write ir_write i_or_d mem_read mem_write reg_dst mem_to_reg reg_write
    // alu_src_a alu_src_b[1:0] alu_op[2:0] pc_src[1:0]
    function automatic logic [15:0] pk(
        input logic pw, input logic iw, input logic iod, input logic mr,
        input logic mw, input logic rd, input logic m2r, input logic rw,
        input logic asa, input logic [1:0] asb, input logic [2:0] aop,
        input logic [1:0] ps);
        pk = {pw, iw, iod, mr, mw, rd, m2r, rw, asa, asb, aop, ps};
    endfunction

    logic [15:0] outs;
    assign outs = pk(pc_write, ir_write, i_or_d, mem_read, mem_write, reg_dst,
                     mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src);

    task automatic check(input string tag, input int unsigned got,
                         input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Check the current cycle, then advance to just after the next edge.
    task automatic cyc(input string tag, input int unsigned st,
                       input logic [15:0] ex);
        #1;
        check({tag, ".state"}, state, st);
        check({tag, ".ctl"}, outs, ex);
        if (mem_read && mem_write) check({tag, ".rdwr"}, 1, 0);
        if (reg_write && mem_write) check({tag, ".rwmw"}, 1, 0);
        @(posedge clk);
        #1;
    endtask

    // Hand-built expected control words per state
    logic [15:0] e_if_rdy, e_if_stl, e_id, e_rd, e_ldwb, e_wr, e_jmp;
    logic [15:0] e_brz_t, e_brz_n, e_exr_sub, e_exr_bad, e_wbr;
    logic [15:0] e_exi_or, e_exi_add, e_wbi;

    initial begin
        e_if_rdy  = pk(1,1,0,1,0,0,0,0, 0,2'b01,3'b001,2'b00);
        e_if_stl  = pk(0,0,0,1,0,0,0,0, 0,2'b01,3'b001,2'b00);
        e_id      = pk(0,0,0,0,0,0,0,0, 0,2'b10,3'b001,2'b00);
        e_rd      = pk(0,0,1,1,0,0,0,0, 0,2'b00,3'b000,2'b00);
        e_ldwb    = pk(0,0,0,0,0,0,1,1, 0,2'b00,3'b000,2'b00);
        e_wr      = pk(0,0,1,0,1,0,0,0, 0,2'b00,3'b000,2'b00);
        e_jmp     = pk(1,0,0,0,0,0,0,0, 0,2'b00,3'b000,2'b10);
        e_brz_t   = pk(1,0,0,0,0,0,0,0, 1,2'b00,3'b010,2'b01);
        e_brz_n   = pk(0,0,0,0,0,0,0,0, 1,2'b00,3'b010,2'b01);
        e_exr_sub = pk(0,0,0,0,0,0,0,0, 1,2'b00,3'b010,2'b00);
        e_exr_bad = pk(0,0,0,0,0,0,0,0, 1,2'b00,3'b000,2'b00);
        e_wbr     = pk(0,0,0,0,0,1,0,1, 0,2'b00,3'b000,2'b00);
        e_exi_or  = pk(0,0,0,0,0,0,0,0, 1,2'b10,3'b100,2'b00);
        e_exi_add = pk(0,0,0,0,0,0,0,0, 1,2'b10,3'b001,2'b00);
        e_wbi     = pk(0,0,0,0,0,0,0,1, 0,2'b00,3'b000,2'b00);

        // Reset: ready held high so an unforced IF would show strobes
        rst = 1'b1; mem_ready = 1'b1; opcode = 4'b0111; func = 3'b000; zero = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc("rst", 0, 16'h0000);
        rst = 1'b0;

        // Fetch stall for 3 cycles, then fetch completes for one cycle
        mem_ready = 1'b0;
        cyc("ifstl0", 0, e_if_stl);
        cyc("ifstl1", 0, e_if_stl);
        cyc("ifstl2", 0, e_if_stl);
        mem_ready = 1'b1;
        // Undefined opcode 0111: 0,1,0 with no writes
        cyc("nop.if", 0, e_if_rdy);
        cyc("nop.id", 1, e_id);

        // R-type SUB
        opcode = 4'b1000; func = 3'b010;
        cyc("sub.if", 0, e_if_rdy);
        cyc("sub.id", 1, e_id);
        cyc("sub.ex", 7, e_exr_sub);
        cyc("sub.wb", 8, e_wbr);

        // R-type with invalid func still writes back
        func = 3'b110;
        cyc("badf.if", 0, e_if_rdy);
        cyc("badf.id", 1, e_id);
        cyc("badf.ex", 7, e_exr_bad);
        cyc("badf.wb", 8, e_wbr);

        // BRZ taken
        opcode = 4'b0100; zero = 1'b1;
        cyc("brzt.if", 0, e_if_rdy);
        cyc("brzt.id", 1, e_id);
        cyc("brzt.br", 6, e_brz_t);
        // BRZ not taken
        zero = 1'b0;
        cyc("brzn.if", 0, e_if_rdy);
        cyc("brzn.id", 1, e_id);
        cyc("brzn.br", 6, e_brz_n);

        // ORI and ADDI
        opcode = 4'b1111;
        cyc("ori.if", 0, e_if_rdy);
        cyc("ori.id", 1, e_id);
        cyc("ori.ex", 9, e_exi_or);
        cyc("ori.wb", 10, e_wbi);
        opcode = 4'b1100;
        cyc("addi.if", 0, e_if_rdy);
        cyc("addi.id", 1, e_id);
        cyc("addi.ex", 9, e_exi_add);
        cyc("addi.wb", 10, e_wbi);

        // LOAD with two stall cycles in MEM_RD: 6 cycles total
        opcode = 4'b0000;
        cyc("ld.if", 0, e_if_rdy);
        cyc("ld.id", 1, e_id);
        mem_ready = 1'b0;
        cyc("ld.rd0", 2, e_rd);
        cyc("ld.rd1", 2, e_rd);
        mem_ready = 1'b1;
        cyc("ld.rd2", 2, e_rd);
        cyc("ld.wb", 3, e_ldwb);

        // JUMP
        opcode = 4'b0010;
        cyc("jmp.if", 0, e_if_rdy);
        cyc("jmp.id", 1, e_id);
        cyc("jmp.j", 5, e_jmp);

        // STORE without stall
        opcode = 4'b0001;
        cyc("st.if", 0, e_if_rdy);
        cyc("st.id", 1, e_id);
        cyc("st.wr", 4, e_wr);

        // STORE stalled, then reset mid-access
        cyc("str.if", 0, e_if_rdy);
        cyc("str.id", 1, e_id);
        mem_ready = 1'b0;
        cyc("str.wr", 4, e_wr);
        rst = 1'b1;
        cyc("str.rst", 4, 16'h0000);
        rst = 1'b0; mem_ready = 1'b1;
        cyc("post.if", 0, e_if_rdy);
        cyc("post.id", 1, e_id);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
